// File: rtl/scr1_tapc_os_if.sv
// JTAG pin and DMI chain-control bundle for the oversampled TAP controller.
// master = the TAP (drives TDO and chain strobes); slave = pads plus DMI transport side.
`ifndef SCR1_DBG_DMI_CH_ID_WIDTH
`define SCR1_DBG_DMI_CH_ID_WIDTH 2
`endif

interface scr1_tapc_os_if;
  logic                                 jtag_tck;
  logic                                 jtag_tms;
  logic                                 jtag_tdi;
  logic                                 jtag_tdo;
  logic                                 jtag_tdo_en;
  logic                                 dtm_ch_sel;
  logic [`SCR1_DBG_DMI_CH_ID_WIDTH-1:0] dtm_ch_id;
  logic                                 dtm_ch_capture;
  logic                                 dtm_ch_shift;
  logic                                 dtm_ch_update;
  logic                                 dtm_ch_tdi;
  logic                                 dtm_ch_tdo;

  modport master (
    input  jtag_tck, jtag_tms, jtag_tdi, dtm_ch_tdo,
    output jtag_tdo, jtag_tdo_en, dtm_ch_sel, dtm_ch_id,
    output dtm_ch_capture, dtm_ch_shift, dtm_ch_update, dtm_ch_tdi
  );

  modport slave (
    output jtag_tck, jtag_tms, jtag_tdi, dtm_ch_tdo,
    input  jtag_tdo, jtag_tdo_en, dtm_ch_sel, dtm_ch_id,
    input  dtm_ch_capture, dtm_ch_shift, dtm_ch_update, dtm_ch_tdi
  );
endinterface

// File: rtl/scr1_tapc_os.sv
// Oversampled JTAG TAP: pins synced on clk, TCK edge events SYNC_STAGES+1 clks after the pin; no backpressure.
// Define SCR1_TAPC_IDCODE_EN to build the IDCODE register (otherwise IDCODE decodes as BYPASS).
module scr1_tapc_os #(
  parameter int          IR_WIDTH    = 5,
  parameter logic [31:0] IDCODE_VAL  = 32'hDEB11001,
  parameter int          SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  scr1_tapc_os_if.master bus
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(5'h01);
  localparam logic [IR_WIDTH-1:0] IR_DTMCS  = IR_WIDTH'(5'h10);
  localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'(5'h11);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS = '1;
`ifdef SCR1_TAPC_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_IDCODE;
  localparam logic [31:0]         IDCODE_FIXED = {IDCODE_VAL[31:1], 1'b1};
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_BYPASS;
`endif

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_t;

  tap_state_t state, state_next;

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic                   tck_d;
  logic                   tck_s, tms_s, tdi_s;
  logic                   tck_rise, tck_fall;

  logic [IR_WIDTH-1:0]    ir_reg, ir_shift;
  logic                   bypass_sr;
  logic                   tdo_q, tdo_en_q;
  logic                   cap_q, shift_q, upd_q;
  logic                   ir_dtmcs, ir_dmi, ch_sel;
  logic                   dr_tdo;

  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_d;
  assign tck_fall = ~tck_s & tck_d;

  assign ir_dtmcs = (ir_reg == IR_DTMCS);
  assign ir_dmi   = (ir_reg == IR_DMI);
  assign ch_sel   = ir_dtmcs | ir_dmi;

`ifdef SCR1_TAPC_IDCODE_EN
  logic [31:0] idcode_sr;
  logic        ir_idcode;
  assign ir_idcode = (ir_reg == IR_IDCODE);
  assign dr_tdo    = ch_sel ? bus.dtm_ch_tdo : (ir_idcode ? idcode_sr[0] : bypass_sr);

  always_ff @(posedge clk) begin
    if (rst) begin
      idcode_sr <= '0;
    end else if (tck_rise && state == CAPTURE_DR) begin
      idcode_sr <= IDCODE_FIXED;
    end else if (tck_rise && state == SHIFT_DR) begin
      idcode_sr <= {tdi_s, idcode_sr[31:1]};
    end
  end
`else
  assign dr_tdo = ch_sel ? bus.dtm_ch_tdo : bypass_sr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_d    <= 1'b0;
      state    <= TEST_LOGIC_RESET;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], bus.jtag_tck};
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], bus.jtag_tms};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], bus.jtag_tdi};
      tck_d    <= tck_s;
      state    <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (tck_rise) begin
      case (state)
        TEST_LOGIC_RESET: state_next = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state_next = tms_s ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:        state_next = tms_s ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       state_next = tms_s ? EXIT1_DR  : SHIFT_DR;
        SHIFT_DR:         state_next = tms_s ? EXIT1_DR  : SHIFT_DR;
        EXIT1_DR:         state_next = tms_s ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         state_next = tms_s ? EXIT2_DR  : PAUSE_DR;
        EXIT2_DR:         state_next = tms_s ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        state_next = tms_s ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:        state_next = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state_next = tms_s ? EXIT1_IR  : SHIFT_IR;
        SHIFT_IR:         state_next = tms_s ? EXIT1_IR  : SHIFT_IR;
        EXIT1_IR:         state_next = tms_s ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         state_next = tms_s ? EXIT2_IR  : PAUSE_IR;
        EXIT2_IR:         state_next = tms_s ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:        state_next = tms_s ? SELECT_DR : RUN_TEST_IDLE;
        default:          state_next = TEST_LOGIC_RESET;
      endcase
    end
  end

  // Strobes use the pre-transition state so each event maps to exactly one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_reg    <= IR_RESET;
      ir_shift  <= '0;
      bypass_sr <= 1'b0;
      cap_q     <= 1'b0;
      shift_q   <= 1'b0;
      upd_q     <= 1'b0;
      tdo_q     <= 1'b0;
      tdo_en_q  <= 1'b0;
    end else begin
      cap_q   <= tck_rise & (state == CAPTURE_DR) & ch_sel;
      shift_q <= tck_rise & (state == SHIFT_DR)   & ch_sel;
      upd_q   <= tck_fall & (state == UPDATE_DR)  & ch_sel;

      if (tck_rise) begin
        case (state)
          CAPTURE_IR: ir_shift  <= IR_WIDTH'(1);
          SHIFT_IR:   ir_shift  <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
          CAPTURE_DR: bypass_sr <= 1'b0;
          SHIFT_DR:   bypass_sr <= tdi_s;
          default:    ;
        endcase
      end

      if (state == TEST_LOGIC_RESET) begin
        ir_reg <= IR_RESET;
      end else if (tck_fall && state == UPDATE_IR) begin
        ir_reg <= ir_shift;
      end

      if (tck_fall) begin
        tdo_en_q <= (state == SHIFT_IR) || (state == SHIFT_DR);
        tdo_q    <= (state == SHIFT_IR) ? ir_shift[0] :
                    (state == SHIFT_DR) ? dr_tdo      : 1'b0;
      end
    end
  end

  assign bus.jtag_tdo       = tdo_q;
  assign bus.jtag_tdo_en    = tdo_en_q;
  assign bus.dtm_ch_sel     = ch_sel;
  assign bus.dtm_ch_id      = ir_dtmcs ? `SCR1_DBG_DMI_CH_ID_WIDTH'(1) :
                              ir_dmi   ? `SCR1_DBG_DMI_CH_ID_WIDTH'(2) : '0;
  assign bus.dtm_ch_capture = cap_q;
  assign bus.dtm_ch_shift   = shift_q;
  assign bus.dtm_ch_update  = upd_q;
  assign bus.dtm_ch_tdi     = tdi_s;

endmodule

// File: tb/tb_scr1_tapc_os.sv
// Directed bench for scr1_tapc_os: bit-bangs JTAG at a slow TCK and models a 41-bit DMI chain.
module tb_scr1_tapc_os;

  localparam logic [40:0] DMI_CAP = 41'h15A5AC3C33C;
  localparam logic [40:0] DMI_IN  = 41'h0F0F1234567;
`ifdef SCR1_TAPC_IDCODE_EN
  localparam logic [63:0] IR_RST  = 64'h01;
`else
  localparam logic [63:0] IR_RST  = 64'h1F;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  scr1_tapc_os_if bus();

  scr1_tapc_os dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // DMI chain model and strobe monitor, sampled mid-cycle
  logic [40:0] mdl    = '0;
  int          n_cap  = 0;
  int          n_sh   = 0;
  int          n_upd  = 0;
  int          n_wide = 0;
  int          n_multi = 0;
  logic        p_cap = 1'b0, p_sh = 1'b0, p_upd = 1'b0;

  assign bus.dtm_ch_tdo = mdl[0];

  always @(negedge clk) begin
    if (bus.dtm_ch_capture)    mdl <= DMI_CAP;
    else if (bus.dtm_ch_shift) mdl <= {bus.dtm_ch_tdi, mdl[40:1]};
    if (bus.dtm_ch_capture) n_cap <= n_cap + 1;
    if (bus.dtm_ch_shift)   n_sh  <= n_sh + 1;
    if (bus.dtm_ch_update)  n_upd <= n_upd + 1;
    if ((bus.dtm_ch_capture && p_cap) || (bus.dtm_ch_shift && p_sh) || (bus.dtm_ch_update && p_upd))
      n_wide <= n_wide + 1;
    if (int'(bus.dtm_ch_capture) + int'(bus.dtm_ch_shift) + int'(bus.dtm_ch_update) > 1)
      n_multi <= n_multi + 1;
    p_cap <= bus.dtm_ch_capture;
    p_sh  <= bus.dtm_ch_shift;
    p_upd <= bus.dtm_ch_update;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo, output logic en);
    bus.jtag_tms = tms;
    bus.jtag_tdi = tdi;
    repeat (3) @(negedge clk);
    bus.jtag_tck = 1'b1;
    repeat (6) @(negedge clk);
    bus.jtag_tck = 1'b0;
    repeat (6) @(negedge clk);
    tdo = bus.jtag_tdo;
    en  = bus.jtag_tdo_en;
  endtask

  // Full scan from RUN_TEST_IDLE back to RUN_TEST_IDLE; dout[k] is the k-th TDO bit.
  task automatic scan(input logic is_ir, input int n, input logic [63:0] din,
                      output logic [63:0] dout, output logic en);
    logic t, e;
    dout = '0;
    tck_cycle(1'b1, 1'b0, t, e);
    if (is_ir) tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    dout[0] = t;
    en      = e;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], t, e);
      if (i < n - 1) dout[i+1] = t;
    end
    tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
  endtask

  initial begin
    logic [63:0] dout;
    logic        en, t, e;
    int          c0, s0, u0;

    bus.jtag_tck = 1'b0;
    bus.jtag_tms = 1'b0;
    bus.jtag_tdi = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_state",  64'(dut.state), 64'd0);
    check("rst_ir",     64'(dut.ir_reg), IR_RST);
    check("rst_tdo",    64'(bus.jtag_tdo), 64'd0);
    check("rst_tdo_en", 64'(bus.jtag_tdo_en), 64'd0);
    check("rst_strobe", 64'({bus.dtm_ch_capture, bus.dtm_ch_shift, bus.dtm_ch_update}), 64'd0);
    rst = 1'b0;

    repeat (5) tck_cycle(1'b1, 1'b0, t, e);
    check("tlr_state",  64'(dut.state), 64'd0);
    check("tlr_ir",     64'(dut.ir_reg), IR_RST);
    check("tlr_tdo_en", 64'(e), 64'd0);
    check("tlr_strobes", 64'(n_cap + n_sh + n_upd), 64'd0);
    tck_cycle(1'b0, 1'b0, t, e);

    scan(1'b0, 32, 64'h3, dout, en);
`ifdef SCR1_TAPC_IDCODE_EN
    check("idcode_out", dout, 64'hDEB11001);
`else
    check("idcode_out", dout, 64'h6);
`endif
    check("dr_tdo_en", 64'(en), 64'd1);

    scan(1'b1, 5, 64'h11, dout, en);
    check("ir_capture", dout, 64'h01);
    check("ir_tdo_en",  64'(en), 64'd1);
    check("idle_tdo_en", 64'(bus.jtag_tdo_en), 64'd0);
    check("dmi_sel", 64'(bus.dtm_ch_sel), 64'd1);
    check("dmi_id",  64'(bus.dtm_ch_id), 64'd2);

    c0 = n_cap; s0 = n_sh; u0 = n_upd;
    scan(1'b0, 41, 64'(DMI_IN), dout, en);
    check("dmi_tdo",   dout, 64'(DMI_CAP));
    check("dmi_tdi",   64'(mdl), 64'(DMI_IN));
    check("dmi_n_cap", 64'(n_cap - c0), 64'd1);
    check("dmi_n_sh",  64'(n_sh - s0), 64'd41);
    check("dmi_n_upd", 64'(n_upd - u0), 64'd1);

    scan(1'b1, 5, 64'h10, dout, en);
    check("dtmcs_sel", 64'(bus.dtm_ch_sel), 64'd1);
    check("dtmcs_id",  64'(bus.dtm_ch_id), 64'd1);

    scan(1'b1, 5, 64'h07, dout, en);
    check("unk_sel", 64'(bus.dtm_ch_sel), 64'd0);
    check("unk_id",  64'(bus.dtm_ch_id), 64'd0);
    c0 = n_cap; s0 = n_sh; u0 = n_upd;
    scan(1'b0, 8, 64'hB6, dout, en);
    check("bypass_tdo", dout, 64'h6C);
    check("bypass_strobes", 64'((n_cap - c0) + (n_sh - s0) + (n_upd - u0)), 64'd0);

    scan(1'b1, 5, 64'h11, dout, en);
    u0 = n_upd;
    tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    repeat (3) tck_cycle(1'b0, 1'b1, t, e);
    check("mid_state", 64'(dut.state), 64'(4));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_state",  64'(dut.state), 64'd0);
    check("abort_ir",     64'(dut.ir_reg), IR_RST);
    check("abort_tdo_en", 64'(bus.jtag_tdo_en), 64'd0);
    tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b1, 1'b0, t, e);
    check("abort_no_upd", 64'(n_upd - u0), 64'd0);

    check("strobe_width", 64'(n_wide), 64'd0);
    check("strobe_onehot", 64'(n_multi), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
